// File: rtl/alu_seq_responder.sv
// Handshaked ALU responder: one registered result per request, with an
// iterative shift-add multiplier for sel 1001 and a held response in DONE.
module alu_seq_responder #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Zero,
  output logic             Cout,
  output logic             Overflow
);

  localparam int LW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d, a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [WIDTH:0]   sum_s, diff_s;
  logic [WIDTH-1:0] alu_y_s, mul_acc_s;
  logic             alu_c_s, alu_v_s;

  assign req_ready = (state_q == IDLE) && !RST;
  assign rsp_valid = (state_q == DONE);
  assign Y         = y_q;
  assign Zero      = zero_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;

  assign mul_acc_s = b_q[0] ? (acc_q + a_q) : acc_q;

  // Single-cycle operations on the live request operands
  always_comb begin
    sum_s   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    diff_s  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    alu_y_s = '0;
    alu_c_s = 1'b0;
    alu_v_s = 1'b0;
    case (sel)
      4'b0000: alu_y_s = A & B;
      4'b0001: alu_y_s = A | B;
      4'b0010: alu_y_s = ~A;
      4'b0011: alu_y_s = A ^ B;
      4'b0100: alu_y_s = ~(A ^ B);
      4'b0101: alu_y_s = ~(A | B);
      4'b0110: begin
        alu_y_s = sum_s[WIDTH-1:0];
        alu_c_s = sum_s[WIDTH];
        alu_v_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0111: begin
        alu_y_s = diff_s[WIDTH-1:0];
        alu_c_s = diff_s[WIDTH];
        alu_v_s = (A[WIDTH-1] == ~B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      // diff carry set means A >= B, so the plain difference is already |A-B|
      4'b1000: alu_y_s = diff_s[WIDTH] ? diff_s[WIDTH-1:0] : (B - A);
      4'b1010, 4'b1011: alu_y_s = {A[WIDTH-2:0], 1'b0};
      4'b1100: alu_y_s = {1'b0, A[WIDTH-1:1]};
      4'b1101: alu_y_s = {A[WIDTH-1], A[WIDTH-1:1]};
      4'b1110: alu_y_s = {{(WIDTH-1){1'b0}}, 1'b1} << A[LW-1:0];
      4'b1111: alu_y_s = A & (~A + {{(WIDTH-1){1'b0}}, 1'b1});
      default: alu_y_s = '0;
    endcase
  end

  // Next-state and datapath update for the IDLE/MUL/DONE sequence
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (sel == 4'b1001) begin
            a_d     = A;
            b_d     = B;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            y_d     = alu_y_s;
            zero_d  = ~|alu_y_s;
            cout_d  = alu_c_s;
            ovf_d   = alu_v_s;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d = mul_acc_s;
        a_d   = {a_q[WIDTH-2:0], 1'b0};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + {{(LW-1){1'b0}}, 1'b1};
        if (cnt_q == LW'(WIDTH - 1)) begin
          y_d     = mul_acc_s;
          zero_d  = ~|mul_acc_s;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = DONE;
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      y_q     <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_responder.sv
// Scoreboard bench for alu_seq_responder: expected responses are queued at
// accept time from a behavioural model and compared when rsp_valid appears.
module tb_alu_seq_responder;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic [3:0]   sel = 4'd0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] Y;
  logic         Zero, Cout, Overflow;

  typedef struct packed {
    logic [W-1:0] y;
    logic         z;
    logic         c;
    logic         v;
  } rsp_t;

  rsp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  alu_seq_responder #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .A(A), .B(B), .Cin(Cin), .sel(sel), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .Y(Y), .Zero(Zero), .Cout(Cout), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  function automatic rsp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic [3:0] s);
    rsp_t     r;
    logic [W:0] wide;
    r = '0;
    case (s)
      4'd0:  r.y = a & b;
      4'd1:  r.y = a | b;
      4'd2:  r.y = ~a;
      4'd3:  r.y = a ^ b;
      4'd4:  r.y = ~(a ^ b);
      4'd5:  r.y = ~(a | b);
      4'd6: begin
        wide = a + b + ci;
        r.y  = wide[W-1:0];
        r.c  = wide[W];
        r.v  = (a[W-1] == b[W-1]) && (r.y[W-1] != a[W-1]);
      end
      4'd7: begin
        r.y = a - b;
        r.c = (a >= b);
        r.v = (a[W-1] != b[W-1]) && (r.y[W-1] != a[W-1]);
      end
      4'd8:  r.y = (a > b) ? a - b : b - a;
      4'd9:  r.y = a * b;
      4'd10, 4'd11: r.y = a << 1;
      4'd12: r.y = a >> 1;
      4'd13: r.y = $signed(a) >>> 1;
      4'd14: r.y = 32'd1 << a[4:0];
      4'd15: r.y = a & (-a);
      default: r.y = '0;
    endcase
    r.z = (r.y == '0);
    return r;
  endfunction

  // Issue one request, check latency and busy state, hold the response for
  // 'hold' cycles with a competing request, then consume it.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [3:0] s, input int hold);
    int   n;
    rsp_t e, got;
    @(negedge CLK);
    A = a; B = b; Cin = ci; sel = s; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: req_ready=%b required 1", req_ready);
    end
    @(posedge CLK);
    sb_q.push_back(model(a, b, ci, s));
    @(negedge CLK);
    req_valid = 1'b0; A = $urandom; B = $urandom; Cin = ~ci; sel = ~s;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin
      checks++;
      if (req_ready !== 1'b0) begin
        errors++; $display("FAIL busy_ready: sel=%h req_ready=%b required 0", s, req_ready);
      end
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n != ((s == 4'd9) ? W : 0)) begin
      errors++; $display("FAIL latency: sel=%h edges=%0d required %0d", s, n, (s == 4'd9) ? W : 0);
    end
    e   = sb_q.pop_front();
    got = {Y, Zero, Cout, Overflow};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL result: sel=%h A=%h B=%h got Y=%h Z=%b C=%b V=%b required Y=%h Z=%b C=%b V=%b",
               s, a, b, got.y, got.z, got.c, got.v, e.y, e.z, e.c, e.v);
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; sel = 4'd0; A = $urandom;
      @(negedge CLK);
      checks++;
      if ({rsp_valid, req_ready} !== 2'b10 || {Y, Zero, Cout, Overflow} !== e) begin
        errors++;
        $display("FAIL backpressure: cyc=%0d rsp_valid=%b req_ready=%b Y=%h required 1 0 Y=%h",
                 i, rsp_valid, req_ready, Y, e.y);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({Y, Zero, Cout, Overflow, rsp_valid, req_ready} !== {{W{1'b0}}, 5'b00000}) begin
      errors++;
      $display("FAIL reset_vals: Y=%h Z=%b C=%b V=%b rv=%b rr=%b required all 0",
               Y, Zero, Cout, Overflow, rsp_valid, req_ready);
    end
    RST = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_add_sub();
    issue(32'h8000_0000, 32'h8000_0000, 1'b0, 4'd6, 0);
    issue(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 4'd6, 0);
    issue(32'h0000_00F0, 32'h0000_00FF, 1'b0, 4'd7, 0);
    issue(32'h0000_00F0, 32'h0000_00FF, 1'b0, 4'd8, 0);
    issue(32'h0000_00FE, 32'h0000_00F4, 1'b0, 4'd7, 0);
    issue(32'h8000_0000, 32'h0000_0001, 1'b0, 4'd7, 0);
  endtask

  task automatic test_mul();
    issue(32'd15, 32'd255, 1'b0, 4'd9, 0);
    issue(32'h0000_400F, 32'h0000_40FF, 1'b0, 4'd9, 0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd9, 0);
  endtask

  task automatic test_shift_decode();
    issue(32'd5, 32'd0, 1'b0, 4'd14, 0);
    issue(32'h0000_00FE, 32'd0, 1'b0, 4'd15, 0);
    issue(32'h1111_12CF, 32'd0, 1'b0, 4'd15, 0);
    issue(32'h0000_0000, 32'd0, 1'b0, 4'd15, 0);
    issue(32'h8000_000F, 32'd0, 1'b0, 4'd13, 0);
    issue(32'h8000_000F, 32'd0, 1'b0, 4'd12, 0);
    issue(32'h8000_000F, 32'd0, 1'b0, 4'd11, 0);
  endtask

  task automatic test_backpressure();
    issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 4'd3, 5);
    issue(32'd7, 32'd9, 1'b0, 4'd9, 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      issue($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 0);
    end
  endtask

  task automatic test_mul_reset();
    @(negedge CLK);
    A = 32'hDEAD_BEEF; B = 32'h0000_1234; sel = 4'd9; req_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (10) @(posedge CLK);
    #1 RST = 1'b1;
    #1;
    checks++;
    if ({Y, Zero, Cout, Overflow, rsp_valid, req_ready} !== {{W{1'b0}}, 5'b00000}) begin
      errors++;
      $display("FAIL mid_reset: Y=%h Z=%b rv=%b rr=%b required all 0", Y, Zero, rsp_valid, req_ready);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: req_ready=%b rsp_valid=%b required 1 0", req_ready, rsp_valid);
    end
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd0, 0);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_shift_decode();
    test_backpressure();
    test_back_to_back();
    test_mul_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
